// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver that samples each bit once at its mid-point,
// checks parity/framing, detects line breaks and queues received frames
// into a show-ahead FIFO with overrun reporting.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int NUM_BITS   = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic [NUM_BITS-1:0] rd_data,
  output logic                rd_parity_err,
  output logic                rd_frame_err,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                break_det,
  output logic                overrun
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC);
  localparam int BW       = 4;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = NUM_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t state, state_next;

  logic                rx_meta;
  logic                rxs;
  logic [CW-1:0]       cyc_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [NUM_BITS-1:0] data_sr;
  logic                par_bit;
  logic                ferr_acc;

  logic                half_end;
  logic                bit_end;
  logic                tick;
  logic                push_req;
  logic                brk_hit;
  logic                break_cond;
  logic                par_calc;
  logic                par_err;
  logic                frame_err_now;

  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                empty;
  logic                full;
  logic                pop;
  logic                push_ok;
  logic [EW-1:0]       push_entry;
  logic [EW-1:0]       head;

  assign half_end      = (cyc_cnt == CW'(HALF_CYC - 1));
  assign bit_end       = (cyc_cnt == CW'(BIT_CYC - 1));
  assign break_cond    = (data_sr == '0) && ((PARITY == 0) || !par_bit) && !rxs;
  assign par_calc      = (^data_sr) ^ par_bit;
  assign par_err       = (PARITY == 1) ? ~par_calc : (PARITY == 2) ? par_calc : 1'b0;
  assign frame_err_now = ferr_acc | ~rxs;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic plus the per-bit sample strobe, push request and break hit
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    push_req   = 1'b0;
    brk_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) state_next = START;
      end
      START: begin
        if (half_end) begin
          tick       = 1'b1;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick = 1'b1;
          if (bit_cnt == BW'(NUM_BITS - 1)) state_next = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (bit_end) begin
          tick       = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          tick = 1'b1;
          if ((bit_cnt == '0) && break_cond) begin
            brk_hit    = 1'b1;
            state_next = BRK;
          end else if (bit_cnt == BW'(STOP_BITS - 1)) begin
            push_req   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      BRK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timing counters and frame assembly; idle states keep everything cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      data_sr  <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (state == IDLE || state == BRK) begin
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      data_sr  <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      cyc_cnt <= tick ? '0 : cyc_cnt + CW'(1);
      if (tick) begin
        case (state)
          DATA: begin
            data_sr <= {rxs, data_sr[NUM_BITS-1:1]};
            bit_cnt <= (bit_cnt == BW'(NUM_BITS - 1)) ? '0 : bit_cnt + BW'(1);
          end
          PAR: par_bit <= rxs;
          STOP: begin
            bit_cnt  <= bit_cnt + BW'(1);
            ferr_acc <= frame_err_now;
          end
          default: ;
        endcase
      end
    end
  end

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !empty && rd_ready;
  assign push_ok    = push_req && (!full || pop);
  assign push_entry = {data_sr, par_err, frame_err_now};
  assign head       = mem[rd_ptr[AW-1:0]];

  assign rd_valid      = !empty;
  assign rd_data       = rd_valid ? head[EW-1:2] : '0;
  assign rd_parity_err = rd_valid ? head[1] : 1'b0;
  assign rd_frame_err  = rd_valid ? head[0] : 1'b0;

  // FIFO storage; a full FIFO accepts a write only when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // FIFO pointers (one extra wrap bit) and the single-cycle status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      break_det <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      break_det <= brk_hit;
      overrun   <= push_req && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at 16 clocks per bit.
// One instance runs 8N1 with a 4-entry FIFO, a second runs 8E1 for parity.
module tb_uart_rx_fifo;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_frame_err;
  logic       rd_valid;
  logic       break_det;
  logic       overrun;

  logic       rx_p = 1'b1;
  logic       rd_ready_p = 1'b0;
  logic [7:0] rd_data_p;
  logic       rd_parity_err_p;
  logic       rd_frame_err_p;
  logic       rd_valid_p;
  logic       break_det_p;
  logic       overrun_p;

  int assert_cnt = 0;
  int fail_cnt = 0;
  int brk_pulses = 0;
  int ovr_pulses = 0;
  int snap;

  uart_rx_fifo #(
    .CLK_FREQ(16), .BAUD_RATE(1), .NUM_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .break_det(break_det), .overrun(overrun)
  );

  uart_rx_fifo #(
    .CLK_FREQ(16), .BAUD_RATE(1), .NUM_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_par (
    .clk(clk), .rst_n(rst_n), .rx(rx_p),
    .rd_data(rd_data_p), .rd_parity_err(rd_parity_err_p), .rd_frame_err(rd_frame_err_p),
    .rd_valid(rd_valid_p), .rd_ready(rd_ready_p), .break_det(break_det_p), .overrun(overrun_p)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count status pulses of the 8N1 instance away from the active edge
  always @(negedge clk) begin
    if (break_det) brk_pulses++;
    if (overrun)   ovr_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] bits, input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      if (sel) rx_p = bits[i];
      else     rx   = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_entry(input bit sel);
    if (sel) rd_ready_p = 1'b1;
    else     rd_ready   = 1'b1;
    @(negedge clk);
    rd_ready_p = 1'b0;
    rd_ready   = 1'b0;
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  initial begin
    logic [7:0] exp_byte;

    // Reset state
    rst_n = 1'b0;
    idle(3);
    checkOutput("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_rd_data", rd_data, 8'h00);
    checkOutput("reset_parity_err", rd_parity_err, 1'b0);
    checkOutput("reset_frame_err", rd_frame_err, 1'b0);
    checkOutput("reset_break_det", break_det, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_par_rd_valid", rd_valid_p, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Plain 8N1 byte, held in the FIFO while the consumer is not ready
    $display("[TB] byte 0xA5");
    applyStimulus(frame8(8'hA5), 10, 1'b0);
    idle(4);
    checkOutput("a5_rd_valid", rd_valid, 1'b1);
    checkOutput("a5_rd_data", rd_data, 8'hA5);
    checkOutput("a5_parity_err", rd_parity_err, 1'b0);
    checkOutput("a5_frame_err", rd_frame_err, 1'b0);
    idle(20);
    checkOutput("a5_held", rd_valid, 1'b1);
    pop_entry(1'b0);
    checkOutput("a5_popped", rd_valid, 1'b0);
    pop_entry(1'b0);
    checkOutput("empty_pop_ignored", rd_valid, 1'b0);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
    $display("[TB] even parity");
    applyStimulus({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 1'b1);
    idle(4);
    checkOutput("par1_rd_valid", rd_valid_p, 1'b1);
    checkOutput("par1_rd_data", rd_data_p, 8'h03);
    checkOutput("par1_parity_err", rd_parity_err_p, 1'b1);
    checkOutput("par1_frame_err", rd_frame_err_p, 1'b0);
    pop_entry(1'b1);
    applyStimulus({5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 1'b1);
    idle(4);
    checkOutput("par0_rd_data", rd_data_p, 8'h03);
    checkOutput("par0_parity_err", rd_parity_err_p, 1'b0);
    pop_entry(1'b1);
    checkOutput("par_drained", rd_valid_p, 1'b0);

    // Stop bit low on a non-zero byte is a framing error, not a break
    $display("[TB] framing error 0x5A");
    snap = brk_pulses;
    applyStimulus({6'b0, 1'b0, 8'h5A, 1'b0}, 10, 1'b0);
    rx = 1'b1;
    idle(24);
    checkOutput("ferr_rd_valid", rd_valid, 1'b1);
    checkOutput("ferr_rd_data", rd_data, 8'h5A);
    checkOutput("ferr_frame_err", rd_frame_err, 1'b1);
    checkOutput("ferr_parity_err", rd_parity_err, 1'b0);
    checkOutput("ferr_no_break", brk_pulses - snap, 0);
    pop_entry(1'b0);
    checkOutput("ferr_single_push", rd_valid, 1'b0);

    // Line held low for 20 bit times, then a normal byte
    $display("[TB] break");
    snap = brk_pulses;
    rx = 1'b0;
    idle(20 * BIT);
    rx = 1'b1;
    idle(32);
    checkOutput("brk_pulse_count", brk_pulses - snap, 1);
    checkOutput("brk_nothing_pushed", rd_valid, 1'b0);
    applyStimulus(frame8(8'h11), 10, 1'b0);
    idle(4);
    checkOutput("post_brk_rd_valid", rd_valid, 1'b1);
    checkOutput("post_brk_rd_data", rd_data, 8'h11);
    checkOutput("post_brk_frame_err", rd_frame_err, 1'b0);
    pop_entry(1'b0);

    // Fill the FIFO, overflow with a fifth frame, then drain in order
    $display("[TB] overrun");
    snap = ovr_pulses;
    for (int i = 1; i <= 4; i++) begin
      exp_byte = 8'(i);
      applyStimulus(frame8(exp_byte), 10, 1'b0);
    end
    idle(4);
    checkOutput("fill_no_overrun", ovr_pulses - snap, 0);
    applyStimulus(frame8(8'h05), 10, 1'b0);
    idle(4);
    checkOutput("ovr_pulse_count", ovr_pulses - snap, 1);
    for (int i = 1; i <= 4; i++) begin
      exp_byte = 8'(i);
      checkOutput("drain_rd_valid", rd_valid, 1'b1);
      checkOutput("drain_rd_data", rd_data, exp_byte);
      pop_entry(1'b0);
    end
    checkOutput("drain_empty", rd_valid, 1'b0);

    // Short low glitch must be rejected at the start mid-point
    $display("[TB] glitch");
    snap = brk_pulses;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    checkOutput("glitch_rd_valid", rd_valid, 1'b0);
    checkOutput("glitch_no_break", brk_pulses - snap, 0);

    // Reset during data bit 3 of 0x7E, then the full byte
    $display("[TB] reset mid-frame");
    applyStimulus(16'b1100, 4, 1'b0);
    rx = 1'b1;
    idle(8);
    rst_n = 1'b0;
    idle(3);
    checkOutput("midrst_rd_valid", rd_valid, 1'b0);
    checkOutput("midrst_break_det", break_det, 1'b0);
    rst_n = 1'b1;
    idle(160);
    checkOutput("midrst_discarded", rd_valid, 1'b0);
    applyStimulus(frame8(8'h7E), 10, 1'b0);
    idle(4);
    checkOutput("7e_rd_valid", rd_valid, 1'b1);
    checkOutput("7e_rd_data", rd_data, 8'h7E);
    checkOutput("7e_parity_err", rd_parity_err, 1'b0);
    checkOutput("7e_frame_err", rd_frame_err, 1'b0);
    pop_entry(1'b0);
    checkOutput("7e_popped", rd_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning serial bit rate; BIT_CYC = CLK_FREQ/BAUD_RATE (integer division), BIT_CYC >= 8.
REQ-003 The block SHALL have parameter NUM_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal range 1..2.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries, a power of 2 and >= 2.
REQ-007 The block SHALL have port clk, input, 1 bit: clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-009 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 The block SHALL have port rd_data, output, NUM_BITS bits: head-of-FIFO data.
REQ-011 The block SHALL have port rd_parity_err, output, 1 bit: parity error flag of the head entry.
REQ-012 The block SHALL have port rd_frame_err, output, 1 bit: framing error flag of the head entry.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: FIFO non-empty.
REQ-014 The block SHALL have port rd_ready, input, 1 bit: consumer accepts the head entry.
REQ-015 The block SHALL have port break_det, output, 1 bit: one-cycle pulse on a break condition.
REQ-016 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a frame is dropped because the FIFO is full.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decisions SHALL use the synchronizer output (rxs).
REQ-018 FSM states SHALL be IDLE, START, DATA, PAR, STOP and BRK; PAR SHALL be skipped when PARITY=0.
REQ-019 IDLE->START SHALL occur when rxs=0; the bit counter and cycle counter SHALL clear.
REQ-020 START SHALL wait BIT_CYC/2 cycles and then sample rxs; 1 is a false start (->IDLE, nothing pushed), 0 goes ->DATA.
REQ-021 DATA, PAR and STOP SHALL sample rxs once every BIT_CYC cycles after the start mid-point; data SHALL be LSB first.
REQ-022 The parity error flag SHALL be set when the XOR of the data bits and the parity bit is 0 for PARITY=1, or 1 for PARITY=2.
REQ-023 The framing error flag SHALL be set if any sampled stop bit is 0.
REQ-024 After the last stop-bit sample, the FSM SHALL go to IDLE in the same cycle, so a start edge is detectable from mid-stop-bit onward.
REQ-025 A break SHALL be all data bits 0, the parity bit 0 if present, and the first stop bit 0; then break_det SHALL pulse one cycle, nothing SHALL be pushed, and the FSM SHALL go ->BRK.
REQ-026 BRK SHALL remain until rxs=1, then go ->IDLE.
REQ-027 A non-break frame SHALL be pushed as {data, parity_err, frame_err} on the cycle of its last stop sample.
REQ-028 The FIFO SHALL be show-ahead: rd_data and the flags are valid whenever rd_valid=1, and a pop occurs on rd_valid & rd_ready.
REQ-029 rd_valid SHALL rise the cycle after a push into an empty FIFO, a latency of 1.
REQ-030 A push while full with no pop in the same cycle SHALL drop the frame and pulse overrun for one cycle; FIFO contents SHALL be unchanged.
REQ-031 A push and a pop in the same cycle while full SHALL both be accepted, with no overrun.
REQ-032 A push and a pop in the same cycle otherwise SHALL leave the count unchanged.
REQ-033 rd_ready while empty SHALL be ignored.
REQ-034 The read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-035 The cycle counter SHALL be $clog2(BIT_CYC) bits.

Reset
REQ-036 While rst_n=0 at a clk edge, the state SHALL become IDLE, the counters SHALL be 0, the FIFO SHALL be empty, rd_valid, break_det and overrun SHALL be 0, rd_data and the flags SHALL be 0, and the synchronizer SHALL be 1.
REQ-037 Reset mid-frame SHALL discard the partial frame; after release the block SHALL wait in IDLE for the next rxs=0.

Verification
REQ-038 With CLK_FREQ=16, BAUD_RATE=1, NUM_BITS=8, PARITY=0 and STOP_BITS=1, sending byte 0xA5 with rd_ready=0 SHALL give rd_valid=1, rd_data=0xA5, rd_parity_err=0 and rd_frame_err=0.
REQ-039 With PARITY=2, sending 0x03 with parity bit 1 SHALL set rd_parity_err=1, and sending it with parity bit 0 SHALL set rd_parity_err=0.
REQ-040 Sending 0x5A with a stop bit of 0 followed by a line return to 1 SHALL give rd_data=0x5A, rd_frame_err=1 and break_det=0.
REQ-041 Holding rx low for 20 bit times SHALL pulse break_det once and push nothing; after rx returns high, the next byte 0x11 SHALL be received correctly.
REQ-042 With FIFO_DEPTH=4 and rd_ready=0, sending 5 frames SHALL pulse overrun on frame 5, and draining SHALL return frames 1..4 in order.
REQ-043 A 4-cycle rx low glitch SHALL be treated as a false start: rd_valid stays 0.
REQ-044 Asserting rst_n=0 during data bit 3 SHALL leave rd_valid=0, and a following frame 0x7E SHALL be received intact.
